// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side arbiter feeding one first-word-fall-through fifo.
// One requester is accepted per cycle; a grant may be held for up to
// BURST_LEN consecutive beats. fifo din/wr_en come from a register stage,
// and the space check includes the in-flight write so the fifo never sees
// wr_en while full.
module fifo_write_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DWIDTH      = 16,
  parameter int COUNT_WIDTH = 5,
  parameter int DEPTH       = 16,
  parameter int BURST_LEN   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DWIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  input  logic [COUNT_WIDTH-1:0]     fifo_data_count,
  output logic [DWIDTH-1:0]          fifo_din,
  output logic                       fifo_wr_en,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(BURST_LEN + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic              fifo_wr_en_q, fifo_wr_en_d;
  logic [DWIDTH-1:0] fifo_din_q, fifo_din_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic [DWIDTH-1:0] data_arr [N_REQ];
  logic [COUNT_WIDTH:0] occupancy;
  logic              space_ok;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic              xfer;
  logic [ID_W-1:0]   xfer_idx;

  // Slice the flat requester data bus into one word per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
  end

  // Count plus the write already on its way; one bit wider so it cannot wrap.
  assign occupancy = {1'b0, fifo_data_count} + {{COUNT_WIDTH{1'b0}}, fifo_wr_en_q};
  assign space_ok  = !fifo_full && (occupancy < (COUNT_WIDTH+1)'(DEPTH));

  // Modulo-N successor of a requester index.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (int'(id) == N_REQ - 1) return '0;
    else return id + ID_W'(1);
  endfunction

  // Round-robin scan: first valid requester starting at rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  // Next-state logic: decides the transfer and updates FSM bookkeeping.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    xfer        = 1'b0;
    xfer_idx    = owner_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && space_ok) begin
          xfer        = 1'b1;
          xfer_idx    = win_idx;
          owner_d     = win_idx;
          burst_cnt_d = BC_W'(1);
          if (BURST_LEN == 1) rr_ptr_d = next_id(win_idx);
          else                state_d  = S_BURST;
        end
      end
      S_BURST: begin
        if (req_valid[owner_q]) begin
          // Stall in place while there is no room; owner keeps the grant.
          if (space_ok) begin
            xfer        = 1'b1;
            burst_cnt_d = burst_cnt_q + BC_W'(1);
            if (burst_cnt_d == BC_W'(BURST_LEN)) begin
              rr_ptr_d = next_id(owner_q);
              state_d  = S_IDLE;
            end
          end
        end else begin
          // Owner went idle mid-burst: give up the grant after one bubble.
          rr_ptr_d = next_id(owner_q);
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  // Output register next values: capture the accepted beat, else hold data.
  always_comb begin
    fifo_wr_en_d = xfer;
    fifo_din_d   = fifo_din_q;
    grant_id_d   = grant_id_q;
    if (xfer) begin
      fifo_din_d = data_arr[xfer_idx];
      grant_id_d = xfer_idx;
    end
  end

  // Combinational outputs; ready is suppressed during reset.
  always_comb begin
    req_ready = '0;
    if (!rst && xfer) req_ready[xfer_idx] = 1'b1;
    busy = (state_q == S_BURST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_din_q   <= '0;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_din_q   <= fifo_din_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_din   = fifo_din_q;
  assign grant_id   = grant_id_q;

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-side arbiter that shares one first-word-fall-through `fifo` instance among `N_REQ` producer streams, e.g. per-core result or instruction streams. It selects one requester per cycle and drives the fifo's `din`/`wr_en` from a register stage. Burst locking lets a producer keep the grant for up to `BURST_LEN` consecutive beats. Fifo occupancy is tracked from `data_count` plus the in-flight write, so the fifo never sees `wr_en` while full. The read side of the fifo is untouched.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `DWIDTH`, 16, data width, equal to fifo `DWIDTH`
- `COUNT_WIDTH`, 5, width of fifo `data_count`
- `DEPTH`, 16, fifo capacity in entries (must be < 2^COUNT_WIDTH)
- `BURST_LEN`, 4, max consecutive beats per grant (>= 1)
- `clk` in 1, single clock; all logic is on the rising edge
- `rst` in 1, synchronous, active-high reset
- `req_valid` in N_REQ, per-requester data valid
- `req_data` in N_REQ*DWIDTH, requester i occupies bits [i*DWIDTH +: DWIDTH]
- `req_ready` out N_REQ, one-hot or zero; a transfer occurs when valid&ready
- `fifo_full` in 1, from fifo `full`
- `fifo_data_count` in COUNT_WIDTH, from fifo `data_count`
- `fifo_din` out DWIDTH, to fifo `din`, registered
- `fifo_wr_en` out 1, to fifo `wr_en`, registered
- `grant_id` out $clog2(N_REQ), index of the last accepted requester, registered
- `busy` out 1, high while the FSM is in BURST

## Operation
- `space_ok = !fifo_full && (fifo_data_count + fifo_wr_en) < DEPTH`, evaluated at COUNT_WIDTH+1 bits, no wrap.
- `rr_ptr` is the round-robin start index. The IDLE winner is the first i with `req_valid[i]`, scanning `rr_ptr, rr_ptr+1, …` modulo N_REQ.
- FSM states: IDLE, BURST. Registers: `owner`, `burst_cnt` (width $clog2(BURST_LEN+1)).
- **IDLE**
  - If a winner exists and `space_ok`: `req_ready[winner]=1`, the transfer happens, `owner<=winner`, `burst_cnt<=1`.
  - If `BURST_LEN==1`: `rr_ptr<=winner+1` (mod N_REQ) and stay in IDLE. Otherwise go to BURST.
  - If there is no winner, or `space_ok=0`: no ready, state unchanged.
- **BURST**, owner valid and `space_ok`:
  - `req_ready[owner]=1` and `burst_cnt` increments.
  - If the new count equals BURST_LEN: `rr_ptr<=owner+1`, go to IDLE.
- **BURST**, owner valid and `!space_ok`: stall; hold state, `owner` and `burst_cnt`; no ready to anyone.
- **BURST**, owner not valid: no ready this cycle; `rr_ptr<=owner+1`, go to IDLE (costs one bubble).
- Output register on each transfer: `fifo_wr_en<=1`, `fifo_din<=req_data[owner-or-winner]`, `grant_id<=index`. Without a transfer, `fifo_wr_en<=0` and `fifo_din`/`grant_id` hold.
- `req_ready` is combinational from state, `req_valid` and `space_ok`.
  - Requesters must hold `req_valid`/`req_data` stable until accepted.
  - `req_ready` never depends on `req_ready` feedback.
- Reset values: state IDLE, `rr_ptr=0`, `owner=0`, `burst_cnt=0`, `fifo_wr_en=0`, `fifo_din=0`, `grant_id=0`, `busy=0`.
  - `req_ready` is forced to 0 while `rst` is high.
  - Reset mid-burst abandons the burst. No beat is accepted in the reset cycle.
  - The beat registered before reset is still presented on `fifo_wr_en` for that one cycle, unless reset clears it at the same edge. It is cleared: `fifo_wr_en=0` after the reset edge.
- Reads performed by the fifo consumer only lower `fifo_data_count`. The space check stays conservative by one cycle and needs no read visibility.

## Timing
- Accept-to-fifo latency: a beat accepted at edge t appears as `fifo_wr_en=1` in cycle t+1 and is written by the fifo at edge t+1.
- Throughput: one beat per cycle sustained while `space_ok` holds.
- Back-to-back writes rely on the `fifo_wr_en` term covering the one-cycle lag of `data_count`.
- Full boundary: with `fifo_data_count=DEPTH-1` and `fifo_wr_en=1`, `space_ok=0` and no ready is given. No overflow is possible.
- Burst rotation: after BURST_LEN beats, the next grant goes to the first valid requester after `owner`, in the same or next cycle (IDLE evaluation).
- Starvation bound: any continuously valid requester is accepted within (N_REQ-1)*(BURST_LEN+1)+1 cycles of available space.

## Test plan
- **Reset.** After reset, all outputs are 0 and `fifo_data_count` stays 0. Then a single write of requester 2 with value 0x0002 → `fifo_wr_en` pulses one cycle later, fifo `dout=0x0002`, count 1.
- **Round robin.** All 4 requesters valid, BURST_LEN=1, data 0x1i00+k → fifo contents in order r0,r1,r2,r3,r0,…; each `req_ready` is one-hot.
- **Burst.** BURST_LEN=4, requesters 0 and 1 continuously valid → four r0 beats, four r1 beats, then r0; `busy` is high during beats 2-4.
- **Fill.** Requester 0 valid forever, no reads, DEPTH=16 → exactly 16 writes; `full` rises and `fifo_wr_en` is never high while `full`. Then one read → exactly one more write.
- **Early drop.** Requester 0 drops valid after 2 of 4 burst beats → one bubble, then the grant passes to requester 1; `rr_ptr` is 1.
- **Mid-burst reset.** Assert `rst` during beat 2 → `fifo_wr_en=0` after the edge, `busy=0`, and the next grant starts from requester 0.
